// File: rtl/uart_fifo_system.sv
// UART transmitter and receiver, each behind a small FIFO, with configurable parity and
// stop-bit count. Received bytes carry parity/framing flags; a full RX FIFO sets overrun.
module uart_fifo_system #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  txByteStart,
  input  logic [DATA_WIDTH-1:0] byteForTx,
  output logic                  tx_ready,
  output logic                  tx,
  input  logic                  rx,
  output logic                  rx_ready,
  input  logic                  rx_pop,
  output logic [DATA_WIDTH-1:0] byteFromRx,
  output logic                  rx_parity_error,
  output logic                  rx_frame_error,
  output logic                  rx_overrun,
  output logic                  rx_new_byte_started
);
  localparam int unsigned BaudDiv = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW    = $clog2(BaudDiv) + 1;
  localparam int unsigned AddrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned BitW    = $clog2(DATA_WIDTH);
  localparam int unsigned EntW    = DATA_WIDTH + 2;

  localparam logic [CntW-1:0] BitEnd  = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] HalfBit = CntW'(BaudDiv / 2);
  localparam logic [CntW-1:0] StopEnd = CntW'(STOP_BITS * BaudDiv - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  function automatic logic par_bit(input logic [DATA_WIDTH-1:0] d);
    par_bit = (PARITY == 1) ? ^d : ~^d;
  endfunction

  // ---------------- TX FIFO ----------------
  logic [DATA_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [AddrW:0]        tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[AddrW] != tx_rd_q[AddrW]) &&
                    (tx_wr_q[AddrW-1:0] == tx_rd_q[AddrW-1:0]);
  assign tx_push  = txByteStart && !tx_full;
  assign tx_ready = !tx_full;
  assign tx_head  = tx_mem_q[tx_rd_q[AddrW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AddrW-1:0]] <= byteForTx;
  end

  // ---------------- TX FSM ----------------
  state_e                tx_state_q, tx_state_d;
  logic [CntW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [BitW-1:0]       tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        tx_pop   = !tx_empty;
      end
      StStart: if (tx_cnt_q == BitEnd) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = StData;
        tx_d       = tx_shift_q[0];
      end
      StData: if (tx_cnt_q == BitEnd) begin
        tx_cnt_d   = '0;
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + 1'b1;
        tx_d       = tx_shift_q[1];
        if (tx_bit_q == LastBit) begin
          tx_state_d = (PARITY != 0) ? StParity : StStop;
          tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
        end
      end
      StParity: if (tx_cnt_q == BitEnd) begin
        tx_cnt_d   = '0;
        tx_state_d = StStop;
        tx_d       = 1'b1;
      end
      StStop: if (tx_cnt_q == StopEnd) begin
        tx_cnt_d   = '0;
        tx_state_d = StIdle;
        tx_d       = 1'b1;
        tx_pop     = !tx_empty;
      end
      default: tx_state_d = StIdle;
    endcase
    // Loading from IDLE or straight out of STOP keeps frames contiguous.
    if (tx_pop) begin
      tx_state_d = StStart;
      tx_cnt_d   = '0;
      tx_shift_d = tx_head;
      tx_par_d   = par_bit(tx_head);
      tx_d       = 1'b0;
    end
    tx_wr_d = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
    tx_rd_d = tx_pop ? tx_rd_q + 1'b1 : tx_rd_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
    end
  end

  assign tx = tx_q;

  // ---------------- RX FSM ----------------
  state_e                rx_state_q, rx_state_d;
  logic [CntW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [BitW-1:0]       rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic                  rx_pulse_q, rx_pulse_d;
  logic                  rx_wr, rx_ferr;

  always_comb begin
    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    rx_pulse_d = 1'b0;
    rx_wr      = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = StStart;
      end
      StStart: if (rx_cnt_q == HalfBit) begin
        rx_cnt_d = '0;
        if (rx_sync_q) begin
          rx_state_d = StIdle;
        end else begin
          rx_state_d = StData;
          rx_bit_d   = '0;
          rx_perr_d  = 1'b0;
          rx_pulse_d = 1'b1;
        end
      end
      StData: if (rx_cnt_q == BitEnd) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[DATA_WIDTH-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == LastBit) rx_state_d = (PARITY != 0) ? StParity : StStop;
      end
      StParity: if (rx_cnt_q == BitEnd) begin
        rx_cnt_d   = '0;
        rx_perr_d  = (rx_sync_q != par_bit(rx_shift_q));
        rx_state_d = StStop;
      end
      StStop: if (rx_cnt_q == BitEnd) begin
        rx_cnt_d   = '0;
        rx_state_d = StIdle;
        rx_wr      = 1'b1;
        rx_ferr    = !rx_sync_q;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [EntW-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AddrW:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic            rx_full, rx_empty, rx_pop_eff, rx_wr_ok, rx_drop;
  logic            rx_ovr_q, rx_ovr_d;
  logic [EntW-1:0] rx_head;

  assign rx_empty   = (rx_wr_q == rx_rd_q);
  assign rx_full    = (rx_wr_q[AddrW] != rx_rd_q[AddrW]) &&
                      (rx_wr_q[AddrW-1:0] == rx_rd_q[AddrW-1:0]);
  assign rx_pop_eff = rx_pop && !rx_empty;
  // A pop in the same cycle frees the slot for the incoming byte.
  assign rx_wr_ok   = rx_wr && (!rx_full || rx_pop_eff);
  assign rx_drop    = rx_wr && rx_full && !rx_pop_eff;
  assign rx_head    = rx_mem_q[rx_rd_q[AddrW-1:0]];

  always_comb begin
    rx_wr_d  = rx_wr_ok ? rx_wr_q + 1'b1 : rx_wr_q;
    rx_rd_d  = rx_pop_eff ? rx_rd_q + 1'b1 : rx_rd_q;
    rx_ovr_d = rx_ovr_q;
    if (rx_pop_eff) rx_ovr_d = 1'b0;
    if (rx_drop)    rx_ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rx_wr_ok) rx_mem_q[rx_wr_q[AddrW-1:0]] <= {rx_shift_q, rx_perr_q, rx_ferr};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_pulse_q <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_pulse_q <= rx_pulse_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  // Head entry is only presented while valid so stale slots never leak out.
  assign rx_ready            = !rx_empty;
  assign byteFromRx          = rx_ready ? rx_head[EntW-1:2] : '0;
  assign rx_parity_error     = rx_ready && rx_head[1];
  assign rx_frame_error      = rx_ready && rx_head[0];
  assign rx_overrun          = rx_ovr_q;
  assign rx_new_byte_started = rx_pulse_q;

endmodule

// File: tb/tb_uart_fifo_system.sv
// Directed bench for uart_fifo_system: three instances (no parity, even-parity loopback with two
// stop bits, odd parity driven from the bench) at 16 clocks per bit.
module tb_uart_fifo_system;
  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 100_000;
  localparam int          BD      = ClkFreq / Baud;
  localparam int unsigned Depth   = 4;
  localparam int          NRec    = 6 + 52 * BD;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  // Instance a: no parity, one stop bit
  logic       a_start = 1'b0, a_rx = 1'b1, a_pop = 1'b0;
  logic [7:0] a_byte = '0, a_rxbyte;
  logic       a_tx_ready, a_tx, a_rx_ready, a_perr, a_ferr, a_ovr, a_pulse;
  // Instance b: even parity, two stop bits, tx looped to rx
  logic       b_start = 1'b0, b_pop = 1'b0;
  logic [7:0] b_byte = '0, b_rxbyte;
  logic       b_tx_ready, b_tx, b_rx_ready, b_perr, b_ferr, b_ovr, b_pulse;
  // Instance c: odd parity, rx driven by the bench
  logic       c_start = 1'b0, c_rx = 1'b1, c_pop = 1'b0;
  logic [7:0] c_byte = '0, c_rxbyte;
  logic       c_tx_ready, c_tx, c_rx_ready, c_perr, c_ferr, c_ovr, c_pulse;

  uart_fifo_system #(.DATA_WIDTH(8), .BAUD_RATE(Baud), .CLK_FREQ(ClkFreq), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(Depth)) u_a (
    .clk(clk), .rstN(rstN), .txByteStart(a_start), .byteForTx(a_byte), .tx_ready(a_tx_ready),
    .tx(a_tx), .rx(a_rx), .rx_ready(a_rx_ready), .rx_pop(a_pop), .byteFromRx(a_rxbyte),
    .rx_parity_error(a_perr), .rx_frame_error(a_ferr), .rx_overrun(a_ovr),
    .rx_new_byte_started(a_pulse));

  uart_fifo_system #(.DATA_WIDTH(8), .BAUD_RATE(Baud), .CLK_FREQ(ClkFreq), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(Depth)) u_b (
    .clk(clk), .rstN(rstN), .txByteStart(b_start), .byteForTx(b_byte), .tx_ready(b_tx_ready),
    .tx(b_tx), .rx(b_tx), .rx_ready(b_rx_ready), .rx_pop(b_pop), .byteFromRx(b_rxbyte),
    .rx_parity_error(b_perr), .rx_frame_error(b_ferr), .rx_overrun(b_ovr),
    .rx_new_byte_started(b_pulse));

  uart_fifo_system #(.DATA_WIDTH(8), .BAUD_RATE(Baud), .CLK_FREQ(ClkFreq), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(Depth)) u_c (
    .clk(clk), .rstN(rstN), .txByteStart(c_start), .byteForTx(c_byte), .tx_ready(c_tx_ready),
    .tx(c_tx), .rx(c_rx), .rx_ready(c_rx_ready), .rx_pop(c_pop), .byteFromRx(c_rxbyte),
    .rx_parity_error(c_perr), .rx_frame_error(c_ferr), .rx_overrun(c_ovr),
    .rx_new_byte_started(c_pulse));

  int n_checks = 0;
  int n_errors = 0;
  int b_pulses = 0;
  int c_pulses = 0;

  always @(posedge clk) begin
    if (b_pulse) b_pulses <= b_pulses + 1;
    if (c_pulse) c_pulses <= c_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return a_tx == 1'b0;
      1:       return b_tx == 1'b0;
      2:       return b_rx_ready == 1'b1;
      default: return c_rx_ready == 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cond(sel)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    a_byte  = d;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic pop_c();
    c_pop = 1'b1;
    @(negedge clk);
    c_pop = 1'b0;
    @(negedge clk);
  endtask

  // Frame on c_rx: start, data LSB first, odd parity (optionally inverted), one stop bit.
  task automatic send_c(input logic [7:0] d, input logic flip, input logic stop_low);
    logic [10:0] bits;
    bits = {~stop_low, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      c_rx = bits[i];
      repeat (BD) @(negedge clk);
    end
    c_rx = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic capture_a(output logic [9:0] bits, output bit ok);
    bits = '0;
    wait_for(0, 8 * BD, ok);
    if (ok) begin
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        bits[i] = a_tx;
        if (i < 9) repeat (BD) @(negedge clk);
      end
      repeat (BD) @(negedge clk);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;  // frame[0] is the first bit on the wire
  } tx_vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       flip;
    logic       stop_low;
    logic       exp_perr;
    logic       exp_ferr;
  } rx_vec_t;

  tx_vec_t    tx_vecs [4];
  rx_vec_t    rx_vecs [5];
  logic [7:0] b2b_bytes [6];
  logic       samp [NRec];

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] got;
    bit         ok;
    int         s0;
    int         pulses_before;

    tx_vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
    tx_vecs[1] = '{data: 8'h00, frame: 10'b1_0000_0000_0};
    tx_vecs[2] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
    tx_vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};

    rx_vecs[0] = '{data: 8'h3C, flip: 1'b0, stop_low: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
    rx_vecs[1] = '{data: 8'h3C, flip: 1'b0, stop_low: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b1};
    rx_vecs[2] = '{data: 8'h3C, flip: 1'b1, stop_low: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b0};
    rx_vecs[3] = '{data: 8'h81, flip: 1'b0, stop_low: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b0};
    rx_vecs[4] = '{data: 8'h00, flip: 1'b1, stop_low: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b1};

    b2b_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset tx lines", {a_tx, b_tx, c_tx}, 3'b111);
    check("reset tx_ready", {a_tx_ready, b_tx_ready, c_tx_ready}, 3'b111);
    check("reset rx_ready", {a_rx_ready, b_rx_ready, c_rx_ready}, 3'b000);
    check("reset byteFromRx", {a_rxbyte, b_rxbyte, c_rxbyte}, 24'h0);
    check("reset flags", {a_perr, a_ferr, a_ovr, a_pulse, c_perr, c_ferr, c_ovr, c_pulse,
                          b_perr, b_ferr, b_ovr, b_pulse}, 12'h000);
    rstN = 1'b1;
    @(negedge clk);

    // TX waveform, no parity
    for (int v = 0; v < 4; v++) begin
      push_a(tx_vecs[v].data);
      check("tx_ready after single push", a_tx_ready, 1'b1);
      capture_a(got, ok);
      check("tx start bit seen", ok, 1'b1);
      check("tx frame bits", got, tx_vecs[v].frame);
    end

    // Even parity loopback with two stop bits
    b_byte  = 8'h07;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_for(1, 8 * BD, ok);
    check("loopback start seen", ok, 1'b1);
    repeat (BD / 2 + 9 * BD) @(negedge clk);
    check("loopback parity bit", b_tx, 1'b1);
    wait_for(2, 6 * BD, ok);
    check("loopback rx_ready", ok, 1'b1);
    check("loopback byte", b_rxbyte, 8'h07);
    check("loopback flags", {b_perr, b_ferr, b_ovr}, 3'b000);
    check("loopback start pulses", b_pulses, 1);

    // Back-to-back pushes: FIFO_DEPTH+1 accepted, then dropped, frames contiguous
    for (int cyc = 0; cyc < NRec; cyc++) begin
      @(negedge clk);
      samp[cyc] = a_tx;
      if (cyc < 6) begin
        check("b2b tx_ready before push", a_tx_ready, (cyc < int'(Depth) + 1) ? 1'b1 : 1'b0);
        a_byte  = b2b_bytes[cyc];
        a_start = 1'b1;
      end else begin
        a_start = 1'b0;
      end
    end
    s0 = -1;
    for (int i = 0; i < NRec; i++) if (samp[i] == 1'b0 && s0 < 0) s0 = i;
    check("b2b first start found", (s0 >= 0) ? 1'b1 : 1'b0, 1'b1);
    if (s0 >= 0) begin
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < 10; i++) got[i] = samp[s0 + k * 10 * BD + BD / 2 + i * BD];
        check("b2b frame bits", got, {1'b1, b2b_bytes[k], 1'b0});
        if (k > 0) check("b2b no idle gap",
                         {samp[s0 + k * 10 * BD - 1], samp[s0 + k * 10 * BD]}, 2'b10);
      end
      check("b2b sixth push dropped", samp[s0 + 50 * BD + BD / 2], 1'b1);
    end
    check("b2b tx_ready after drain", a_tx_ready, 1'b1);

    // RX error flags, odd parity
    for (int v = 0; v < 5; v++) begin
      pulses_before = c_pulses;
      send_c(rx_vecs[v].data, rx_vecs[v].flip, rx_vecs[v].stop_low);
      wait_for(3, 2 * BD, ok);
      check("rx entry ready", ok, 1'b1);
      check("rx byte", c_rxbyte, rx_vecs[v].data);
      check("rx parity error", c_perr, rx_vecs[v].exp_perr);
      check("rx frame error", c_ferr, rx_vecs[v].exp_ferr);
      check("rx start pulse count", c_pulses - pulses_before, 1);
      pop_c();
      check("rx empty after pop", c_rx_ready, 1'b0);
    end

    // Overrun: FIFO_DEPTH+1 frames without popping
    for (int k = 0; k < 5; k++) begin
      send_c(8'h10 * (k + 1), 1'b0, 1'b0);
      if (k == 3) check("no overrun at depth", c_ovr, 1'b0);
    end
    check("overrun set", c_ovr, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("overrun kept byte", c_rxbyte, 8'h10 * (k + 1));
      pop_c();
      if (k == 0) check("overrun cleared by pop", c_ovr, 1'b0);
    end
    check("overrun fifo drained", c_rx_ready, 1'b0);

    // Short low glitch on rx
    pulses_before = c_pulses;
    c_rx = 1'b0;
    repeat (4) @(negedge clk);
    c_rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    check("glitch no start pulse", c_pulses - pulses_before, 0);
    check("glitch no entry", c_rx_ready, 1'b0);

    // Reset in the middle of a TX frame, with an RX entry pending
    send_c(8'h5A, 1'b0, 1'b0);
    check("pre-reset rx entry", c_rx_ready, 1'b1);
    push_a(8'h00);
    push_a(8'h00);
    wait_for(0, 8 * BD, ok);
    check("pre-reset tx started", ok, 1'b1);
    repeat (3 * BD) @(negedge clk);
    check("pre-reset tx in data", a_tx, 1'b0);
    #2 rstN = 1'b0;
    #1;
    check("mid-frame reset tx high", a_tx, 1'b1);
    check("mid-frame reset tx_ready", a_tx_ready, 1'b1);
    check("mid-frame reset rx_ready", c_rx_ready, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("post-reset tx idle", a_tx, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
